// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers A and B, then streams diagonally skewed wavefronts into a systolic array
module systolic_skew_feeder #(
    parameter int DIM          = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int DRAIN_CYCLES = 2 * DIM
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [0:DIM*DATA_WIDTH-1]     load_row_a,
    input  logic [0:DIM*DATA_WIDTH-1]     load_row_b,
    input  logic                          start,
    output logic                          acc_clear,
    output logic [0:DIM*DATA_WIDTH-1]     in_row,
    output logic [0:DIM*DATA_WIDTH-1]     in_col,
    output logic                          busy,
    output logic                          done
);
    localparam int RW   = DIM > 1 ? $clog2(DIM) : 1;
    localparam int SMAX = (2 * DIM - 2 > DRAIN_CYCLES - 1) ? 2 * DIM - 2 : DRAIN_CYCLES - 1;
    localparam int SW   = $clog2(SMAX + 1);

    typedef enum logic [2:0] {LOAD, LOADED, CLEAR, FEED, DRAIN} state_t;
    typedef logic [0:DIM-1][DATA_WIDTH-1:0] row_t;

    state_t        state, state_nxt;
    logic [RW-1:0] r, r_nxt;
    logic [SW-1:0] s, s_nxt;
    row_t          a_rows [DIM];
    row_t          b_rows [DIM];
    row_t          row_nxt, col_nxt;

    // next-state and counter logic; the step counter is shared by FEED and DRAIN
    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        s_nxt     = s;
        case (state)
            LOAD: if (load_valid) begin
                state_nxt = (r == RW'(DIM - 1)) ? LOADED : LOAD;
                r_nxt     = (r == RW'(DIM - 1)) ? '0 : r + 1'b1;
            end
            LOADED: state_nxt = start ? CLEAR : LOADED;
            CLEAR: begin
                state_nxt = FEED;
                s_nxt     = '0;
            end
            FEED: begin
                state_nxt = (s == SW'(2 * DIM - 2)) ? DRAIN : FEED;
                s_nxt     = (s == SW'(2 * DIM - 2)) ? '0 : s + 1'b1;
            end
            DRAIN: begin
                state_nxt = (s == SW'(DRAIN_CYCLES - 1)) ? LOAD : DRAIN;
                s_nxt     = (s == SW'(DRAIN_CYCLES - 1)) ? '0 : s + 1'b1;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // lane j carries A[j][s-j] and B[s-j][j] while that index lies inside the matrix
    for (genvar j = 0; j < DIM; j++) begin : g_lane
        logic [SW-1:0] k;
        logic          hit;
        assign k          = s_nxt - SW'(j);
        assign hit        = state_nxt == FEED && s_nxt >= SW'(j) && k < SW'(DIM);
        assign row_nxt[j] = hit ? a_rows[j][k[RW-1:0]] : '0;
        assign col_nxt[j] = hit ? b_rows[k[RW-1:0]][j] : '0;
    end

    // state, counters and registered outputs derived from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            r          <= '0;
            s          <= '0;
            load_ready <= 1'b1;
            acc_clear  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_row     <= '0;
            in_col     <= '0;
        end else begin
            state      <= state_nxt;
            r          <= r_nxt;
            s          <= s_nxt;
            load_ready <= state_nxt == LOAD;
            acc_clear  <= state_nxt == CLEAR;
            busy       <= state_nxt inside {CLEAR, FEED, DRAIN};
            done       <= state == DRAIN && state_nxt == LOAD;
            in_row     <= row_nxt;
            in_col     <= col_nxt;
        end
    end

    // operand storage; contents survive reset and are overwritten by the next load
    always_ff @(posedge clk) begin
        if (state == LOAD && load_valid) begin
            a_rows[r] <= load_row_a;
            b_rows[r] <= load_row_b;
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: randomized bench with a behavioural wavefront model and directed scenarios
module tb_systolic_skew_feeder;
    localparam int DIM = 4;
    localparam int DW  = 8;
    localparam int DR  = 8;
    localparam int N   = DIM * DW;

    typedef logic [0:DIM-1][DW-1:0] row_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load_valid = 1'b0;
    logic start = 1'b0;
    row_t load_row_a = '0;
    row_t load_row_b = '0;
    logic load_ready, acc_clear, busy, done;
    row_t in_row, in_col;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.DIM(DIM), .DATA_WIDTH(DW), .DRAIN_CYCLES(DR)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_row_a(load_row_a), .load_row_b(load_row_b), .start(start),
        .acc_clear(acc_clear), .in_row(in_row), .in_col(in_col), .busy(busy), .done(done)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: rows loaded so far and edges elapsed since the accepted start
    row_t ma [DIM];
    row_t mb [DIM];
    int   rows = 0;
    int   t = -1;
    logic e_ready = 1'b1, e_clear = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    row_t e_row = '0, e_col = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rows   = 0;
            t      = -1;
            e_done = 1'b0;
        end else begin
            e_done = 1'b0;
            if (t >= 0) begin
                t++;
                if (t == 2 * DIM + DR) begin
                    t      = -1;
                    rows   = 0;
                    e_done = 1'b1;
                end
            end else if (rows == DIM) begin
                if (start) t = 0;
            end else if (load_valid) begin
                ma[rows] = load_row_a;
                mb[rows] = load_row_b;
                rows++;
            end
        end
        e_ready = t < 0 && rows < DIM;
        e_clear = t == 0;
        e_busy  = t >= 0;
        e_row   = '0;
        e_col   = '0;
        for (int j = 0; j < DIM; j++) begin
            int k;
            k = t - 1 - j;
            if (t >= 1 && t <= 2 * DIM - 1 && k >= 0 && k < DIM) begin
                e_row[j] = ma[j][k];
                e_col[j] = mb[k][j];
            end
        end
    end

    always @(negedge clk) begin
        check("load_ready", load_ready, e_ready);
        check("acc_clear", acc_clear, e_clear);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("in_row", in_row, e_row);
        check("in_col", in_col, e_col);
    end

    row_t sa [DIM];
    row_t sb [DIM];
    row_t crow [0:99];
    row_t ccol [0:99];
    logic clr0;
    int   done_at;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_all(input bit gaps);
        int r;
        r = 0;
        while (r < DIM) begin
            load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            start      = 1'($urandom_range(0, 1));
            load_row_a = sa[r];
            load_row_b = sb[r];
            tick;
            if (load_valid) r++;
        end
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    // drives start for one edge, then records every cycle until done (bounded)
    task automatic run_product;
        start = 1'b1;
        tick;
        start   = 1'b0;
        clr0    = acc_clear;
        done_at = -1;
        for (int c = 1; c < 100 && done_at < 0; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            load_row_a = row_t'($urandom);
            load_row_b = row_t'($urandom);
            tick;
            crow[c] = in_row;
            ccol[c] = in_col;
            if (done) done_at = c;
        end
        load_valid = 1'b0;
        start      = 1'b0;
        if (done_at < 0) check("done_timeout", 0, 1);
    endtask

    // PE(i,j) of a systolic array sees lane i delayed by j and lane j delayed by i
    task automatic check_product;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                int acc, ref_v, ta, tb;
                acc   = 0;
                ref_v = 0;
                for (int k = 0; k < DIM; k++) ref_v += int'(sa[i][k]) * int'(sb[k][j]);
                for (int x = 0; x < 3 * DIM; x++) begin
                    ta = x - j;
                    tb = x - i;
                    if (ta >= 0 && ta < 2 * DIM - 1 && tb >= 0 && tb < 2 * DIM - 1)
                        acc += int'(crow[ta + 1][i]) * int'(ccol[tb + 1][j]);
                end
                check("product", acc, ref_v);
            end
        end
    endtask

    initial begin
        bit pat [7];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        repeat (3) tick;
        reset = 1'b0;
        tick;
        check("rst_ready", load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_row", in_row, 0);

        for (int i = 0; i < DIM; i++)
            for (int k = 0; k < DIM; k++) begin
                sa[i][k] = (i == k) ? 8'd1 : 8'd0;
                sb[i][k] = 8'(4 * i + k + 1);
            end

        // backpressured load with a premature start after two rows
        begin
            int r;
            r = 0;
            for (int i = 0; i < 7; i++) begin
                load_valid = pat[i];
                start      = (i == 4 || i == 5);
                load_row_a = sa[r];
                load_row_b = sb[r];
                tick;
                if (pat[i]) r++;
                if (i == 5) begin
                    check("early_start_clear", acc_clear, 0);
                    check("early_start_busy", busy, 0);
                    check("ready_before_last", load_ready, 1);
                end
            end
            check("rows_accepted", r, 4);
            check("ready_after_load", load_ready, 0);
        end
        load_valid = 1'b1;
        start      = 1'b0;
        load_row_a = row_t'($urandom);
        repeat (3) tick;
        load_valid = 1'b0;

        run_product;
        check("clear_pulse", clr0, 1);
        check("step0_row", crow[1], 32'h0100_0000);
        check("step0_col", ccol[1], 32'h0100_0000);
        check("step3_col", ccol[4], 32'h0D0A_0704);
        check("step6_row", crow[7], 32'h0000_0001);
        check("step6_col", ccol[7], 32'h0000_0010);
        check("done_latency", done_at, 2 * DIM + DR);
        check_product;

        // reset partway through FEED
        for (int i = 0; i < DIM; i++) begin
            sa[i] = row_t'($urandom);
            sb[i] = row_t'($urandom);
        end
        load_all(1);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        #1 reset = 1'b1;
        #1;
        check("midreset_row", in_row, 0);
        check("midreset_col", in_col, 0);
        check("midreset_ready", load_ready, 1);
        check("midreset_busy", busy, 0);
        #1 reset = 1'b0;
        tick;
        load_all(1);
        run_product;
        check_product;

        // lane packing: a single non-zero element lands in the top byte of lane 0
        for (int i = 0; i < DIM; i++) begin
            sa[i] = '0;
            sb[i] = '0;
        end
        sa[0][0] = 8'hA5;
        load_all(0);
        run_product;
        check("pack_step0", crow[1], 32'hA500_0000);
        check("pack_step1", crow[2], 32'h0000_0000);

        // back-to-back random products
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < DIM; i++) begin
                sa[i] = row_t'($urandom);
                sb[i] = row_t'($urandom);
            end
            load_all(1);
            run_product;
            check_product;
        end

        repeat (2) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
